imem_loader: RTL

//  Write-side counterpart of Instruction_Memory_ROM. Receives a framed byte stream

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_loader.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types, frame constants and helpers for the instruction-memory loader.
package imem_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHK   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    // Frame constants: shortest legal payload and instruction word size in bytes
    localparam int LEN_MIN    = 1;
    localparam int WORD_BYTES = 4;

    // A LEN byte is legal when non-zero, fits in memory and is a whole number of words
    function automatic logic len_legal(input logic [7:0] len, input logic [31:0] depth);
        logic [31:0] len_w;
        len_w     = {24'd0, len};
        len_legal = (len_w >= 32'(LEN_MIN)) &&
                    (len_w <= depth) &&
                    ((len_w % 32'(WORD_BYTES)) == 32'd0);
    endfunction

    // Running 8-bit modular checksum
    function automatic logic [7:0] checksum_add(input logic [7:0] sum, input logic [7:0] b);
        checksum_add = sum + b;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Loads a framed byte stream [LEN][data...][CHK] into instruction memory and
// holds the CPU until a frame has been written and its checksum verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [8:0]        byte_count
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t              state_q, state_d;
    logic [7:0]          len_q, len_d;
    logic [8:0]          count_q, count_d;
    logic [7:0]          sum_q, sum_d;
    logic                in_ready_q, in_ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                xfer_s;
    logic                last_byte_s;

    assign xfer_s      = in_valid & in_ready_q;
    assign last_byte_s = ((count_q + 9'd1) == {1'b0, len_q});

    // Next-state, counter, checksum and write-port decode
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                // in_ready is low here, so in_data is never consumed on the start edge
                if (start) begin
                    state_d = ST_LEN;
                    count_d = 9'd0;
                    sum_d   = 8'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN: begin
                if (xfer_s) begin
                    len_d = in_data;
                    if (len_legal(in_data, DEPTH_W)) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    wdata_d = in_data;
                    count_d = count_q + 9'd1;
                    sum_d   = checksum_add(sum_q, in_data);
                    if (last_byte_s) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CHK: begin
                if (xfer_s) begin
                    if (checksum_add(sum_q, in_data) == 8'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else begin
                    state_d = ST_CHK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered copies of what the next state implies
        in_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CHK);
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERROR);
        hold_d     = (state_d != ST_DONE);
    end

    // State and output registers; async reset aborts any frame in progress
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            len_q      <= 8'd0;
            count_q    <= 9'd0;
            sum_q      <= 8'd0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 8'd0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign error      = error_q;
    assign byte_count = count_q;

endmodule
